imm_encoder: RTL and testbench
==============================

# imm_encoder

Sequential encoder that converts a 32-bit constant into the ARM data-processing rotated-immediate operand field, {rot[3:0], imm8[7:0]}, where the decoded value is imm8 rotated right by 2*rot. It is the inverse of the operand shifter's immediate path. It sits beside the instruction assembler/loader and tests one rotation per cycle. When the value has no direct encoding, it also reports whether the bitwise complement is encodable, so the loader can substitute MVN/BIC forms.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  input  1  request pulse; sampled only in IDLE
- value  input  32  constant to encode; captured on accepted start
- busy  output  1  high in SEARCH and DONE
- done  output  1  one-cycle pulse when result is valid
- found  output  1  an encoding (direct or inverted) exists; held until next accepted start
- inverted  output  1  data12Out encodes ~value, not value; held
- data12Out  output  12  {rot, imm8}; held; 12'h000 when found=0

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 captures value into valReg.
  - Clears rotCnt, found, inverted, data12Out and the pending-inverted record.
  - Next state is SEARCH.
- SEARCH, evaluated each cycle at rotation r = rotCnt (0..15):
  - Direct test: cand = ROL(valReg, 2r). Hit when cand[31:8]==0.
  - Inverted test: the same test applied to ~valReg.
  - On a direct hit: latch data12Out={r, cand[7:0]}, found=1, inverted=0, go to DONE. A direct hit at the smallest r always wins.
  - On an inverted hit with no direct hit: if no inverted hit is recorded yet, record {r, imm8}. Searching continues.
  - If r==15 with no direct hit: when an inverted record exists, output it with found=1, inverted=1. Otherwise found=0, data12Out=0. Go to DONE.
  - Otherwise rotCnt increments.
- DONE: done=1 for exactly one cycle, then return to IDLE. Results stay held.
- Value 0 encodes directly at r=0 as 12'h000 with found=1.
- start while busy is ignored; it is neither queued nor allowed to alter the capture.
- rotCnt is 4 bits. The shift amount 2r is 5 bits. There is no wrap past 15, because r==15 always exits.

## Timing
- Start accepted at cycle 0 (IDLE). SEARCH with r=0 occurs at cycle 1.
- Direct hit at rotation r: done at cycle r+2.
- Inverted-only result or not found: done at cycle 17.
- Back-to-back operation: start is accepted on the cycle after done, so the minimum period is 3 cycles.
- Reset is asynchronous at any time, including mid-SEARCH. After reset: state IDLE, busy=0, done=0, found=0, inverted=0, data12Out=0. The first rising edge after deassertion may accept start.
- Outputs are registered. There is no combinational path from start or value to any output.

## Structure
- Shared package holds:
  - the state enum (IDLE, SEARCH, DONE)
  - ROT_LAST=4'd15
  - IMM_FIELD_W=12
- The package is also suitable for reuse by the operand shifter.
- Natural sub-module: rot_fit_check. It is combinational and takes (data[31:0], rot[3:0]) to produce (hit, imm8[7:0]). It is instantiated twice: once for valReg and once for ~valReg.

## Test plan
- value=32'h000000FF, start -> done at cycle 2, found=1, inverted=0, data12Out=12'h0FF.
- value=32'hFF000000 -> done at cycle 6, data12Out=12'h4FF.
- value=32'h00000104 -> done at cycle 17, data12Out=12'hF41 (wrap-around rotation).
- value=32'hFFFFFF00 -> done at cycle 17, found=1, inverted=1, data12Out=12'h0FF.
- value=32'h00000101 -> done at cycle 17, found=0, inverted=0, data12Out=12'h000.
- Control cases:
  - Pulse start with value=32'h1 while busy -> first result is unchanged, second start is ignored.
  - Assert reset at cycle 5 of a search -> all outputs 0 immediately, then a new start completes normally.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the rotated-immediate encoder and operand shifter.
package imm_encoder_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ROT_W       = 4;
    localparam int unsigned IMM8_W      = 8;
    localparam int unsigned SHAMT_W     = 5;
    localparam int unsigned IMM_FIELD_W = 12;

    localparam logic [ROT_W-1:0] ROT_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } enc_state_e;

    // Rotation field counts in units of two bit positions.
    function automatic logic [SHAMT_W-1:0] rot_amount(input logic [ROT_W-1:0] rot);
        return {rot, 1'b0};
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bundle between the assembler/loader and the immediate encoder.
interface imm_encoder_if;
    import imm_encoder_pkg::*;

    logic                   start;
    logic [DATA_W-1:0]      value;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic                   inverted;
    logic [IMM_FIELD_W-1:0] data12Out;

    modport master (
        output start, value,
        input  busy, done, found, inverted, data12Out
    );

    modport slave (
        input  start, value,
        output busy, done, found, inverted, data12Out
    );

endinterface

// File: rtl/imm_encoder_rot_fit_check.sv
// Checks whether data fits an 8-bit immediate once rotated left by 2*rot.
module imm_encoder_rot_fit_check
    import imm_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [ROT_W-1:0]  rot,
    output logic              hit,
    output logic [IMM8_W-1:0] imm8
);

    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   cand;

    // Rotate-left taken from the upper half of a doubled word.
    assign dbl  = {data, data} << rot_amount(rot);
    assign cand = dbl[2*DATA_W-1:DATA_W];
    assign hit  = (cand[DATA_W-1:IMM8_W] == '0);
    assign imm8 = cand[IMM8_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Searches one rotation per cycle for a direct or complemented ARM rotated-immediate encoding.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    imm_encoder_if.slave bus
);

    enc_state_e             state_q, state_d;
    logic [ROT_W-1:0]       rot_q, rot_d;
    logic [DATA_W-1:0]      val_q, val_d;
    logic                   pend_q, pend_d;
    logic [IMM_FIELD_W-1:0] rec_q, rec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   found_q, found_d;
    logic                   inv_q, inv_d;
    logic [IMM_FIELD_W-1:0] data_q, data_d;

    logic                   dir_hit, inv_hit;
    logic [IMM8_W-1:0]      dir_imm, inv_imm;

    imm_encoder_rot_fit_check u_fit_direct (
        .data (val_q),
        .rot  (rot_q),
        .hit  (dir_hit),
        .imm8 (dir_imm)
    );

    imm_encoder_rot_fit_check u_fit_inverted (
        .data (~val_q),
        .rot  (rot_q),
        .hit  (inv_hit),
        .imm8 (inv_imm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rot_q   <= '0;
            val_q   <= '0;
            pend_q  <= 1'b0;
            rec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            inv_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            val_q   <= val_d;
            pend_q  <= pend_d;
            rec_q   <= rec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        val_d   = val_q;
        pend_d  = pend_q;
        rec_d   = rec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        found_d = found_q;
        inv_d   = inv_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    val_d   = bus.value;
                    rot_d   = '0;
                    pend_d  = 1'b0;
                    rec_d   = '0;
                    found_d = 1'b0;
                    inv_d   = 1'b0;
                    data_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (dir_hit) begin
                    data_d  = {rot_q, dir_imm};
                    found_d = 1'b1;
                    inv_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // Keep only the first (smallest rotation) complement hit.
                    if (inv_hit && !pend_q) begin
                        pend_d = 1'b1;
                        rec_d  = {rot_q, inv_imm};
                    end
                    if (rot_q == ROT_LAST) begin
                        if (pend_q || inv_hit) begin
                            found_d = 1'b1;
                            inv_d   = 1'b1;
                            data_d  = pend_q ? rec_q : {rot_q, inv_imm};
                        end
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rot_d = rot_q + 4'd1;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.inverted  = inv_q;
    assign bus.data12Out = data_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, control sequences, randomized vs. decode model.
module tb_imm_encoder;

    typedef struct {
        logic [31:0] value;
        logic        found;
        logic        inverted;
        logic [11:0] data;
        int          cycles;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} >> s;
        return t[31:0];
    endfunction

    // Reference: try every (rot, imm8) pair and decode it; smallest rotation wins.
    function automatic vec_t model(input logic [31:0] v);
        vec_t m;
        m.value    = v;
        m.found    = 1'b0;
        m.inverted = 1'b0;
        m.data     = 12'h000;
        m.cycles   = 17;
        for (int r = 15; r >= 0; r--)
            for (int i = 0; i < 256; i++)
                if (ror32(32'(i), 5'(2 * r)) == ~v) begin
                    m.found    = 1'b1;
                    m.inverted = 1'b1;
                    m.data     = {4'(r), 8'(i)};
                end
        for (int r = 15; r >= 0; r--)
            for (int i = 0; i < 256; i++)
                if (ror32(32'(i), 5'(2 * r)) == v) begin
                    m.found    = 1'b1;
                    m.inverted = 1'b0;
                    m.data     = {4'(r), 8'(i)};
                    m.cycles   = r + 2;
                end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({bus.busy, bus.done, bus.found, bus.inverted, bus.data12Out}), 32'h0);
    endtask

    // Wait for done, counting cycles from the one in which 'cyc' was last observed.
    task automatic wait_done(inout int cyc, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'(cyc), 32'hFFFF_FFFF);
    endtask

    task automatic run_op(input logic [31:0] v, output vec_t got);
        int   cyc;
        logic ok;
        @(negedge clk);
        bus.value = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        wait_done(cyc, ok);
        got.value    = v;
        got.found    = bus.found;
        got.inverted = bus.inverted;
        got.data     = bus.data12Out;
        got.cycles   = ok ? cyc : -1;
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        check({tag, "_cycles"},   32'(got.cycles),   32'(exp.cycles));
        check({tag, "_found"},    32'(got.found),    32'(exp.found));
        check({tag, "_inverted"}, 32'(got.inverted), 32'(exp.inverted));
        check({tag, "_data"},     32'(got.data),     32'(exp.data));
    endtask

    vec_t vecs [7];

    initial begin
        vec_t got, exp;
        int   cyc;
        logic ok;
        logic saw_busy;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{32'h0000_00FF, 1'b1, 1'b0, 12'h0FF, 2};
        vecs[1] = '{32'hFF00_0000, 1'b1, 1'b0, 12'h4FF, 6};
        vecs[2] = '{32'h0000_0104, 1'b1, 1'b0, 12'hF41, 17};
        vecs[3] = '{32'hFFFF_FF00, 1'b1, 1'b1, 12'h0FF, 17};
        vecs[4] = '{32'h0000_0101, 1'b0, 1'b0, 12'h000, 17};
        vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 12'h000, 2};
        vecs[6] = '{32'h0000_FF00, 1'b1, 1'b0, 12'hCFF, 14};

        bus.start = 1'b0;
        bus.value = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_outputs");
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].value, got);
            compare($sformatf("vec%0d", i), got, vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(bus.done), 32'h0);
            check($sformatf("vec%0d_held", i), 32'(bus.data12Out), 32'(vecs[i].data));
        end

        // A start pulse while busy must not disturb the running search.
        @(negedge clk);
        bus.value = 32'hFF00_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("busy_in_search", 32'(bus.busy), 32'h1);
        @(negedge clk);
        bus.value = 32'h0000_0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.value = '0;
        cyc = 2;
        wait_done(cyc, ok);
        check("ignore_cycles", 32'(cyc), 32'd6);
        check("ignore_data", 32'(bus.data12Out), 32'h4FF);
        check("ignore_found", 32'(bus.found), 32'h1);
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_busy |= bus.busy | bus.done;
        end
        check("ignore_no_second_op", 32'(saw_busy), 32'h0);

        // Reset mid-search clears everything at once; next request runs normally.
        run_op(32'h0000_00FF, got);
        @(negedge clk);
        bus.value = 32'h0000_0101;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_idle("reset_mid_search");
        @(negedge clk);
        reset = 1'b0;
        saw_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_busy |= bus.busy | bus.done;
        end
        check("reset_stays_idle", 32'(saw_busy), 32'h0);
        run_op(32'h0000_FF00, got);
        compare("after_reset", got, model(32'h0000_FF00));

        // Randomized: direct-encodable, complement-encodable and arbitrary values.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] base, v;
            int sel;
            sel  = $urandom_range(0, 2);
            base = ror32(32'($urandom_range(0, 255)), 5'(2 * $urandom_range(0, 15)));
            v    = (sel == 0) ? base : (sel == 1) ? ~base : $urandom();
            exp  = model(v);
            run_op(v, got);
            compare($sformatf("rand%0d_%08h", k, v), got, exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
